uxa_ps2_tx: RTL and testbench
=============================

// Module: uxa_ps2_tx
// PURPOSE
//  Host-to-device PS/2 transmitter for the UXA adapter; sends commands such as LED set and reset to the keyboard.
//  - Accepts one byte from the CPU-side register logic.
//  - Inhibits the bus, issues request-to-send, then shifts out data, parity and stop bits on device-generated clocks.
//  - Reports ACK or error. Drives the open-collector PS/2 lines beside the receive deserializer and 16-byte receive FIFO.
//  - busy_o gates the receive path while a send is in progress.
// PARAMETERS
//  INHIBIT_CYCLES  5000    sys_clk cycles ps2_clk is held low (100us at 50MHz)
//  TIMEOUT_CYCLES  750000  max sys_clk cycles between device clock falls (15ms)
//  CNT_W           20      width of the shared timing counter; must hold both values above
// PORTS
//  sys_clk_i     in   1  system clock; single clock domain
//  sys_reset_i   in   1  synchronous, active-high reset
//  d_i           in   8  byte to send; sampled only on an accepted we_i
//  we_i          in   1  start strobe; accepted only when busy_o=0
//  busy_o        out  1  high from accept until DONE completes
//  done_o        out  1  one-cycle pulse at end of transfer
//  ack_o         out  1  valid with done_o: 1 = device ACKed (data low at 11th clock fall)
//  err_o         out  1  one-cycle pulse on timeout or missing ACK
//  ps2_clk_i     in   1  raw PS/2 clock pin level (asynchronous)
//  ps2_dat_i     in   1  raw PS/2 data pin level (asynchronous)
//  ps2_clk_oe_o  out  1  1 = pull clock line low; 0 = release
//  ps2_dat_oe_o  out  1  1 = pull data line low; 0 = release
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, counters 0. Reset mid-transfer releases both lines on the next edge; no done/err pulse.
//  Synchronisation: ps2 inputs pass 2 FFs. A clock fall (fall) = synced clk was 1 last cycle and is 0 now.
//  States and transitions:
//   IDLE: we_i & ~reset -> latch d_i into shreg, compute parity = ~^d_i (odd), cnt=0 -> INHIBIT.
//   INHIBIT: clk_oe=1; cnt counts to INHIBIT_CYCLES-1 -> RTS.
//   RTS (1 cycle): clk_oe=1, dat_oe=1 (start bit) -> SEND.
//   SEND: clk_oe=0 and bitcnt=0 on entry; dat_oe stays 1 until first fall.
//    - On fall n (n=1..8): dat_oe = ~shreg[n-1] (LSB first).
//    - Fall 9: dat_oe = ~parity. Fall 10: dat_oe=0 (stop bit).
//    - Fall 11: ack_r = ~dat_sync -> WAITIDLE.
//   WAITIDLE: both lines released; wait until clk_sync & dat_sync = 1 -> DONE.
//   DONE (1 cycle): done_o=1, ack_o=ack_r, err_o=~ack_r -> IDLE.
//  Data changes only in the cycle after a detected fall (clock low); the device samples on rise.
//  Timeout: in SEND/WAITIDLE cnt resets on every fall.
//   - cnt reaching TIMEOUT_CYCLES-1 releases both lines, pulses done_o and err_o with ack_o=0 -> IDLE.
//  busy_o = (state != IDLE). we_i while busy is ignored; d_i not resampled.
//  we_i in the same cycle as DONE is ignored; accepted from IDLE next cycle.
//  Widths: bitcnt 4 bits (0..11); cnt CNT_W bits, no wrap before limit compare.
//  Falls seen in IDLE/INHIBIT/RTS are ignored; the receiver owns them.
// STRUCTURE
//  Shared include uxa_ps2_defs.vh: state encodings, PS2_FRAME_BITS=11, default timing constants.
//  Sub-module uxa_ps2_sync: 2-FF synchroniser plus fall detector for clk and dat. Reused by the receive deserializer.
//  Body: one FSM, one timing counter, one bit counter, 8-bit shift/hold register.
// TESTING (bench: INHIBIT_CYCLES=8, TIMEOUT_CYCLES=200, device BFM clock period 40 cycles)
//  Reset: hold sys_reset_i 3 cycles -> all outputs 0, busy_o=0.
//  Send 0xED: clk_oe=1 for exactly 8 cycles, then dat_oe=1 with clk released.
//   - BFM samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1; BFM ACKs.
//   - Expect done_o pulse, ack_o=1, err_o=0.
//  Send 0xF4 -> BFM sees parity 0. Send 0x00 -> parity 1. Both ACKed, done_o once each.
//  we_i=1 with d_i=0xAA at cycle 3 of a 0x55 send -> ignored; BFM receives 0x55 only, one done_o.
//  BFM stops clocking after fall 5 -> 200 cycles later both oe=0, done_o=1, err_o=1, ack_o=0.
//  BFM leaves data high at fall 11 -> done_o with ack_o=0, err_o=1.
//  sys_reset_i pulsed at fall 4 -> both oe=0 next cycle, busy_o=0, no done_o/err_o.

Source files
------------

// File: rtl/uxa_ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module : uxa_ps2_pkg
// Brief  : Shared PS/2 host-transmit types, frame constants and timing defaults
// Rev    : 1.0 - initial release
// ============================================================================
package uxa_ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INHIBIT  = 3'd1,
        S_RTS      = 3'd2,
        S_SEND     = 3'd3,
        S_WAITIDLE = 3'd4,
        S_DONE     = 3'd5
    } ps2_tx_state_t;

    localparam int c_frame_bits           = 11;
    localparam int c_inhibit_cycles_def   = 5000;
    localparam int c_timeout_cycles_def   = 750000;
    localparam int c_cnt_w_def            = 20;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uxa_ps2_sync.sv
`default_nettype none
// ============================================================================
// Module : uxa_ps2_sync
// Brief  : Two-flop synchroniser for PS/2 clk/dat plus clock falling-edge detect
// Rev    : 1.0 - initial release
// ============================================================================
module uxa_ps2_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_ps2_clk,
    input  logic i_ps2_dat,
    output logic o_clk_sync,
    output logic o_dat_sync,
    output logic o_clk_fall
);

    logic [1:0] w_raw;
    logic [1:0] w_sync;
    logic       r_clk_prev;

    assign w_raw = {i_ps2_dat, i_ps2_clk};

    // Idle bus level is high, so flops reset high to avoid a phantom fall.
    generate
        for (genvar g = 0; g < 2; g++) begin : g_line
            logic r_meta;
            logic r_sync;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_meta <= 1'b1;
                    r_sync <= 1'b1;
                end else begin
                    r_meta <= w_raw[g];
                    r_sync <= r_meta;
                end
            end
            assign w_sync[g] = r_sync;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_prev <= w_sync[0];
        end
    end

    assign o_clk_sync = w_sync[0];
    assign o_dat_sync = w_sync[1];
    assign o_clk_fall = r_clk_prev & ~w_sync[0];

endmodule
`default_nettype wire

// File: rtl/uxa_ps2_tx.sv
`default_nettype none
// ============================================================================
// Module : uxa_ps2_tx
// Brief  : PS/2 host-to-device transmitter (inhibit, RTS, frame shift, ACK)
// Rev    : 1.0 - initial release
// ============================================================================
module uxa_ps2_tx
    import uxa_ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = c_inhibit_cycles_def,
    parameter int TIMEOUT_CYCLES = c_timeout_cycles_def,
    parameter int CNT_W          = c_cnt_w_def
) (
    input  logic       sys_clk_i,
    input  logic       sys_reset_i,
    input  logic [7:0] d_i,
    input  logic       we_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       ack_o,
    output logic       err_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_dat_oe_o
);

    localparam logic [CNT_W-1:0] c_inh_last = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_to_last  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       c_last_bit = 4'(c_frame_bits);

    ps2_tx_state_t    r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_bitcnt, w_bitcnt_nxt, w_fall_idx;
    logic [7:0]       r_shreg, w_shreg_nxt;
    logic             r_parity, w_parity_nxt;
    logic             r_ack, w_ack_nxt;
    logic             r_clk_oe, w_clk_oe_nxt;
    logic             r_dat_oe, w_dat_oe_nxt;
    logic             r_done, w_done_nxt;
    logic             r_ack_out, w_ack_out_nxt;
    logic             r_err, w_err_nxt;
    logic             w_clk_sync, w_dat_sync, w_fall;

    uxa_ps2_sync u_sync (
        .clk        (sys_clk_i),
        .rst        (sys_reset_i),
        .i_ps2_clk  (ps2_clk_i),
        .i_ps2_dat  (ps2_dat_i),
        .o_clk_sync (w_clk_sync),
        .o_dat_sync (w_dat_sync),
        .o_clk_fall (w_fall)
    );

    always_ff @(posedge sys_clk_i) begin
        if (sys_reset_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bitcnt  <= '0;
            r_shreg   <= '0;
            r_parity  <= 1'b0;
            r_ack     <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_dat_oe  <= 1'b0;
            r_done    <= 1'b0;
            r_ack_out <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_shreg   <= w_shreg_nxt;
            r_parity  <= w_parity_nxt;
            r_ack     <= w_ack_nxt;
            r_clk_oe  <= w_clk_oe_nxt;
            r_dat_oe  <= w_dat_oe_nxt;
            r_done    <= w_done_nxt;
            r_ack_out <= w_ack_out_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bitcnt_nxt  = r_bitcnt;
        w_shreg_nxt   = r_shreg;
        w_parity_nxt  = r_parity;
        w_ack_nxt     = r_ack;
        w_clk_oe_nxt  = r_clk_oe;
        w_dat_oe_nxt  = r_dat_oe;
        w_done_nxt    = 1'b0;
        w_ack_out_nxt = 1'b0;
        w_err_nxt     = 1'b0;
        w_fall_idx    = r_bitcnt + 4'd1;

        case (r_state)
            S_IDLE: begin
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
                if (we_i) begin
                    w_shreg_nxt  = d_i;
                    w_parity_nxt = odd_parity(d_i);
                    w_cnt_nxt    = '0;
                    w_bitcnt_nxt = '0;
                    w_clk_oe_nxt = 1'b1;
                    w_state_nxt  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (r_cnt == c_inh_last) begin
                    w_cnt_nxt    = '0;
                    w_dat_oe_nxt = 1'b1;
                    w_state_nxt  = S_RTS;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RTS: begin
                w_clk_oe_nxt = 1'b0;
                w_bitcnt_nxt = '0;
                w_cnt_nxt    = '0;
                w_state_nxt  = S_SEND;
            end
            S_SEND: begin
                // Line changes land one cycle after the detected fall, while the
                // device is still holding clock low.
                if (w_fall) begin
                    w_cnt_nxt    = '0;
                    w_bitcnt_nxt = w_fall_idx;
                    if (w_fall_idx <= 4'd8) begin
                        w_dat_oe_nxt = ~r_shreg[r_bitcnt[2:0]];
                    end else if (w_fall_idx == 4'd9) begin
                        w_dat_oe_nxt = ~r_parity;
                    end else if (w_fall_idx < c_last_bit) begin
                        w_dat_oe_nxt = 1'b0;
                    end else begin
                        w_ack_nxt    = ~w_dat_sync;
                        w_dat_oe_nxt = 1'b0;
                        w_state_nxt  = S_WAITIDLE;
                    end
                end else if (r_cnt == c_to_last) begin
                    w_clk_oe_nxt = 1'b0;
                    w_dat_oe_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_err_nxt    = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WAITIDLE: begin
                if (w_clk_sync && w_dat_sync) begin
                    w_done_nxt    = 1'b1;
                    w_ack_out_nxt = r_ack;
                    w_err_nxt     = ~r_ack;
                    w_state_nxt   = S_DONE;
                end else if (w_fall) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_to_last) begin
                    w_clk_oe_nxt = 1'b0;
                    w_dat_oe_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_err_nxt    = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = r_done;
    assign ack_o        = r_ack_out;
    assign err_o        = r_err;
    assign ps2_clk_oe_o = r_clk_oe;
    assign ps2_dat_oe_o = r_dat_oe;

endmodule
`default_nettype wire

// File: tb/tb_uxa_ps2_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_uxa_ps2_tx
// Brief  : Self-checking bench for uxa_ps2_tx with a PS/2 device model
// Rev    : 1.0 - initial release
// ============================================================================
module tb_uxa_ps2_tx;

    localparam int INH  = 8;
    localparam int TO   = 200;
    localparam int HALF = 20;

    localparam int M_ACK   = 0;
    localparam int M_STALL = 1;
    localparam int M_NOACK = 2;
    localparam int M_RESET = 3;

    typedef struct packed {
        logic ack;
        logic err;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d;
    logic       we;
    logic       busy, done, ack, err;
    logic       clk_oe, dat_oe;
    logic       bfm_clk, bfm_dat;
    logic       clk_line, dat_line;

    int   n_tests  = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   cyc      = 0;
    res_t exp_q[$];

    // Open-collector bus: either side can pull a line low.
    assign clk_line = bfm_clk & ~clk_oe;
    assign dat_line = bfm_dat & ~dat_oe;

    uxa_ps2_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (20)
    ) dut (
        .sys_clk_i    (clk),
        .sys_reset_i  (rst),
        .d_i          (d),
        .we_i         (we),
        .busy_o       (busy),
        .done_o       (done),
        .ack_o        (ack),
        .err_o        (err),
        .ps2_clk_i    (clk_line),
        .ps2_dat_i    (dat_line),
        .ps2_clk_oe_o (clk_oe),
        .ps2_dat_oe_o (dat_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame as the device sees it on the wire: index 0 start .. 10 stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Per-cycle invariants plus result scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (!busy) begin
                check("idle_clk_oe", clk_oe, 0);
                check("idle_dat_oe", dat_oe, 0);
            end
            if (err) check("err_implies_done", done, 1);
            if (ack) check("ack_implies_done", done, 1);
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done ack=%0b err=%0b, expected no done (t=%0t)",
                             ack, err, $time);
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    check("done_ack", ack, r.ack);
                    check("done_err", err, r.err);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input int mode, input bit glitch, output logic [10:0] seen);
        int   n_inh;
        int   waited;
        int   t_fall;
        int   dc0;
        res_t r;
        seen = '1;
        dc0  = done_cnt;
        if (mode == M_ACK) begin
            r.ack = 1'b1; r.err = 1'b0; exp_q.push_back(r);
        end else if (mode != M_RESET) begin
            r.ack = 1'b0; r.err = 1'b1; exp_q.push_back(r);
        end
        d  = b;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        d  = 8'($urandom);
        n_inh = 0;
        while (clk_oe && !dat_oe && n_inh < 100) begin
            n_inh++;
            if (glitch && n_inh == 3) begin
                we = 1'b1;
                d  = 8'hAA;
            end else begin
                we = 1'b0;
            end
            @(negedge clk);
        end
        we = 1'b0;
        check("inhibit_len", n_inh, INH);
        check("rts_clk_oe", clk_oe, 1);
        check("rts_dat_oe", dat_oe, 1);
        @(negedge clk);
        check("send_clk_released", clk_oe, 0);
        check("start_dat_oe", dat_oe, 1);
        repeat ($urandom_range(2, 30)) @(negedge clk);
        seen[0] = dat_line;
        for (int n = 1; n <= 11; n++) begin
            bfm_clk = 1'b0;
            t_fall  = cyc;
            if (mode == M_RESET && n == 4) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_clk_oe", clk_oe, 0);
                check("rst_dat_oe", dat_oe, 0);
                check("rst_busy", busy, 0);
                bfm_clk = 1'b1;
                repeat (60) @(negedge clk);
                check("rst_no_done", done_cnt - dc0, 0);
                return;
            end
            repeat (HALF) @(negedge clk);
            bfm_clk = 1'b1;
            if (n <= 10) seen[n] = dat_line;
            if (mode == M_ACK && n == 10) bfm_dat = 1'b0;
            if (mode == M_STALL && n == 5) begin
                waited = 0;
                while (!done && waited < 400) begin
                    @(negedge clk);
                    waited++;
                end
                check("timeout_latency_ok", (cyc - t_fall >= TO) && (cyc - t_fall <= TO + 6), 1);
                check("timeout_clk_oe", clk_oe, 0);
                check("timeout_dat_oe", dat_oe, 0);
                repeat (5) @(negedge clk);
                check("timeout_busy", busy, 0);
                check("timeout_one_done", done_cnt - dc0, 1);
                return;
            end
            repeat (HALF) @(negedge clk);
        end
        bfm_dat = 1'b1;
        waited = 0;
        while (done_cnt == dc0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        repeat (30) @(negedge clk);
        check("one_done", done_cnt - dc0, 1);
        check("post_busy", busy, 0);
        check("post_clk_oe", clk_oe, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] seen;
        logic [7:0]  b;
        int          mode;
        rst = 1'b1; we = 1'b0; d = '0; bfm_clk = 1'b1; bfm_dat = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ack", ack, 0);
        check("reset_err", err, 0);
        check("reset_clk_oe", clk_oe, 0);
        check("reset_dat_oe", dat_oe, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send(8'hED, M_ACK, 1'b0, seen);
        check("frame_ED_model", seen, frame_of(8'hED));
        check("frame_ED_literal", seen, 11'b11111011010);

        send(8'hF4, M_ACK, 1'b0, seen);
        check("frame_F4_model", seen, frame_of(8'hF4));
        check("parity_F4", seen[9], 0);

        send(8'h00, M_ACK, 1'b0, seen);
        check("frame_00_literal", seen, 11'b11000000000);

        send(8'h55, M_ACK, 1'b1, seen);
        check("frame_55_glitch", seen, frame_of(8'h55));
        check("data_55_glitch", seen[8:1], 8'h55);

        for (int k = 0; k < 8; k++) begin
            b    = 8'($urandom);
            mode = ($urandom_range(0, 3) == 0) ? M_NOACK : M_ACK;
            send(b, mode, 1'b0, seen);
            check("frame_random", seen, frame_of(b));
            repeat ($urandom_range(1, 20)) @(negedge clk);
        end

        b = 8'($urandom);
        send(b, M_STALL, 1'b0, seen);
        check("frame_stall_prefix", seen[5:0], 6'(frame_of(b)));

        b = 8'($urandom);
        send(b, M_NOACK, 1'b0, seen);
        check("frame_noack", seen, frame_of(b));

        send(8'hFF, M_RESET, 1'b0, seen);
        check("scoreboard_empty_after_reset", exp_q.size(), 0);

        b = 8'($urandom);
        send(b, M_ACK, 1'b0, seen);
        check("frame_after_reset", seen, frame_of(b));

        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
